// File: rtl/complex_pkg.sv
// Shared types and width helpers for the complex ALU: op encoding, derived widths,
// and the range check / saturate-or-truncate reduction applied to each result component.
package complex_pkg;

    typedef enum logic [1:0] {
        ADD  = 2'b00,
        SUB  = 2'b01,
        MUL  = 2'b10,
        CMUL = 2'b11
    } op_e;

    localparam int CALC_W = 64;

    function automatic int prod_w(input int w);
        return 2 * w;
    endfunction

    function automatic int res_w(input int w);
        return 2 * w + 1;
    endfunction

    function automatic logic signed [CALC_W-1:0] comp_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [CALC_W-1:0] comp_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    function automatic logic comp_ovf(input logic signed [CALC_W-1:0] v, input int w);
        return (v > comp_max(w)) || (v < comp_min(w));
    endfunction

    // Caller keeps the low w bits: with sat=0 this is plain truncation.
    function automatic logic signed [CALC_W-1:0] reduce_comp(input logic signed [CALC_W-1:0] v,
                                                            input int w, input logic sat);
        if (sat && (v > comp_max(w))) return comp_max(w);
        if (sat && (v < comp_min(w))) return comp_min(w);
        return v;
    endfunction

endpackage

// File: rtl/complex_pipe_alu_if.sv
// Loader/consumer bus of the complex ALU: operand writes, compute request handshake, result handshake.
// master = loader/consumer side, slave = the ALU.
interface complex_pipe_alu_if #(
    parameter int W  = 5,
    parameter int AW = 5
);
    logic                   write;
    logic [AW-1:0]          wr_addr_a;
    logic [AW-1:0]          wr_addr_b;
    logic [2*W-1:0]         wr_data_a;
    logic [2*W-1:0]         wr_data_b;
    logic                   in_valid;
    logic                   in_ready;
    logic [1:0]             op;
    logic [AW-1:0]          rd_addr_a;
    logic [AW-1:0]          rd_addr_b;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*(2*W+1)-1:0]   result;
    logic [2*W-1:0]         result_sat;
    logic                   overflow_real;
    logic                   overflow_imaginary;

    modport master (
        output write, wr_addr_a, wr_addr_b, wr_data_a, wr_data_b,
        output in_valid, op, rd_addr_a, rd_addr_b, out_ready,
        input  in_ready, out_valid, result, result_sat, overflow_real, overflow_imaginary
    );

    modport slave (
        input  write, wr_addr_a, wr_addr_b, wr_data_a, wr_data_b,
        input  in_valid, op, rd_addr_a, rd_addr_b, out_ready,
        output in_ready, out_valid, result, result_sat, overflow_real, overflow_imaginary
    );
endinterface

// File: rtl/complex_regfile.sv
// DEPTH x 2W operand store: two write ports (B wins on equal address), two combinational
// write-first read ports; zero latency reads, writes never stall.
module complex_regfile #(
    parameter int W     = 5,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            write_i,
    input  logic [AW-1:0]   wr_addr_a_i,
    input  logic [AW-1:0]   wr_addr_b_i,
    input  logic [2*W-1:0]  wr_data_a_i,
    input  logic [2*W-1:0]  wr_data_b_i,
    input  logic [AW-1:0]   rd_addr_a_i,
    input  logic [AW-1:0]   rd_addr_b_i,
    output logic [2*W-1:0]  rd_data_a_o,
    output logic [2*W-1:0]  rd_data_b_o
);
    logic [2*W-1:0] mem_q [DEPTH];

    // Port B is written last so it overrides port A on an address collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (write_i) begin
            mem_q[wr_addr_a_i] <= wr_data_a_i;
            mem_q[wr_addr_b_i] <= wr_data_b_i;
        end
    end

    always_comb begin
        rd_data_a_o = mem_q[rd_addr_a_i];
        if (write_i && (wr_addr_a_i == rd_addr_a_i)) rd_data_a_o = wr_data_a_i;
        if (write_i && (wr_addr_b_i == rd_addr_a_i)) rd_data_a_o = wr_data_b_i;
    end

    always_comb begin
        rd_data_b_o = mem_q[rd_addr_b_i];
        if (write_i && (wr_addr_a_i == rd_addr_b_i)) rd_data_b_o = wr_data_a_i;
        if (write_i && (wr_addr_b_i == rd_addr_b_i)) rd_data_b_o = wr_data_b_i;
    end

endmodule

// File: rtl/complex_pipe_alu.sv
// Register file + 2-stage complex ALU (add/sub/mul/conj-mul); result valid 2 edges after accept.
// Stalls whole pipe while out_valid && !out_ready; in_ready = !stall; writes never stall.
module complex_pipe_alu #(
    parameter int W        = 5,
    parameter int DEPTH    = 32,
    parameter int AW       = $clog2(DEPTH),
    parameter int SATURATE = 0
) (
    input  logic              clk,
    input  logic              reset,
    complex_pipe_alu_if.slave alu
);
    import complex_pkg::*;

    localparam int PW = prod_w(W);
    localparam int RW = res_w(W);

    logic [2*W-1:0] rd_a, rd_b;

    complex_regfile #(.W(W), .DEPTH(DEPTH), .AW(AW)) u_regfile (
        .clk         (clk),
        .reset       (reset),
        .write_i     (alu.write),
        .wr_addr_a_i (alu.wr_addr_a),
        .wr_addr_b_i (alu.wr_addr_b),
        .wr_data_a_i (alu.wr_data_a),
        .wr_data_b_i (alu.wr_data_b),
        .rd_addr_a_i (alu.rd_addr_a),
        .rd_addr_b_i (alu.rd_addr_b),
        .rd_data_a_o (rd_a),
        .rd_data_b_o (rd_b)
    );

    logic stall;
    logic out_vld_q, out_vld_d;

    assign stall        = out_vld_q && !alu.out_ready;
    assign alu.in_ready = !stall;

    logic signed [W-1:0] op_a, op_b, op_c, op_d;
    assign op_a = rd_a[2*W-1:W];
    assign op_b = rd_a[W-1:0];
    assign op_c = rd_b[2*W-1:W];
    assign op_d = rd_b[W-1:0];

    // Stage 1: operand read, products and component sums.
    logic                 s1_vld_q, s1_vld_d;
    op_e                  s1_op_q, s1_op_d;
    logic signed [PW-1:0] s1_ac_q, s1_ac_d, s1_bd_q, s1_bd_d;
    logic signed [PW-1:0] s1_ad_q, s1_ad_d, s1_bc_q, s1_bc_d;
    logic signed [RW-1:0] s1_sre_q, s1_sre_d, s1_sim_q, s1_sim_d;

    always_comb begin
        s1_vld_d = s1_vld_q;
        s1_op_d  = s1_op_q;
        s1_ac_d  = s1_ac_q;
        s1_bd_d  = s1_bd_q;
        s1_ad_d  = s1_ad_q;
        s1_bc_d  = s1_bc_q;
        s1_sre_d = s1_sre_q;
        s1_sim_d = s1_sim_q;
        if (!stall) begin
            s1_vld_d = alu.in_valid;
            if (alu.in_valid) begin
                s1_op_d = op_e'(alu.op);
                s1_ac_d = PW'(op_a) * PW'(op_c);
                s1_bd_d = PW'(op_b) * PW'(op_d);
                s1_ad_d = PW'(op_a) * PW'(op_d);
                s1_bc_d = PW'(op_b) * PW'(op_c);
                if (op_e'(alu.op) == SUB) begin
                    s1_sre_d = RW'(op_a) - RW'(op_c);
                    s1_sim_d = RW'(op_b) - RW'(op_d);
                end else begin
                    s1_sre_d = RW'(op_a) + RW'(op_c);
                    s1_sim_d = RW'(op_b) + RW'(op_d);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld_q <= 1'b0;
            s1_op_q  <= ADD;
            s1_ac_q  <= '0;
            s1_bd_q  <= '0;
            s1_ad_q  <= '0;
            s1_bc_q  <= '0;
            s1_sre_q <= '0;
            s1_sim_q <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s1_op_q  <= s1_op_d;
            s1_ac_q  <= s1_ac_d;
            s1_bd_q  <= s1_bd_d;
            s1_ad_q  <= s1_ad_d;
            s1_bc_q  <= s1_bc_d;
            s1_sre_q <= s1_sre_d;
            s1_sim_q <= s1_sim_d;
        end
    end

    // Stage 2: combine into exact 2W+1 bit components.
    logic signed [RW-1:0] s2_re, s2_im;

    always_comb begin
        s2_re = s1_sre_q;
        s2_im = s1_sim_q;
        case (s1_op_q)
            MUL: begin
                s2_re = RW'(s1_ac_q) - RW'(s1_bd_q);
                s2_im = RW'(s1_ad_q) + RW'(s1_bc_q);
            end
            CMUL: begin
                s2_re = RW'(s1_ac_q) + RW'(s1_bd_q);
                s2_im = RW'(s1_bc_q) - RW'(s1_ad_q);
            end
            default: ;
        endcase
    end

    logic signed [RW-1:0] res_re_q, res_re_d, res_im_q, res_im_d;
    logic [2*W-1:0]       sat_q, sat_d;
    logic                 ovr_q, ovr_d, ovi_q, ovi_d;

    // Output registers only load when a valid result moves in, so data holds across bubbles.
    always_comb begin
        out_vld_d = out_vld_q;
        res_re_d  = res_re_q;
        res_im_d  = res_im_q;
        sat_d     = sat_q;
        ovr_d     = ovr_q;
        ovi_d     = ovi_q;
        if (!stall) begin
            out_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                res_re_d = s2_re;
                res_im_d = s2_im;
                sat_d    = {W'(reduce_comp(64'(s2_re), W, SATURATE != 0)),
                            W'(reduce_comp(64'(s2_im), W, SATURATE != 0))};
                ovr_d    = comp_ovf(64'(s2_re), W);
                ovi_d    = comp_ovf(64'(s2_im), W);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_vld_q <= 1'b0;
            res_re_q  <= '0;
            res_im_q  <= '0;
            sat_q     <= '0;
            ovr_q     <= 1'b0;
            ovi_q     <= 1'b0;
        end else begin
            out_vld_q <= out_vld_d;
            res_re_q  <= res_re_d;
            res_im_q  <= res_im_d;
            sat_q     <= sat_d;
            ovr_q     <= ovr_d;
            ovi_q     <= ovi_d;
        end
    end

    assign alu.out_valid          = out_vld_q;
    assign alu.result             = {res_re_q, res_im_q};
    assign alu.result_sat         = sat_q;
    assign alu.overflow_real      = ovr_q;
    assign alu.overflow_imaginary = ovi_q;

endmodule

// File: tb/tb_complex_pipe_alu.sv
// Bench for complex_pipe_alu: saturating and truncating instances driven in lockstep,
// results checked against a scoreboard filled by an integer reference model at accept time.
module tb_complex_pipe_alu;
    localparam int W     = 5;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int RW    = 2 * W + 1;
    localparam int HI    = (1 << (W - 1)) - 1;
    localparam int LO    = -(1 << (W - 1));

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic           write, in_valid, out_ready;
    logic [AW-1:0]  wa_a, wa_b, ra_a, ra_b;
    logic [2*W-1:0] wd_a, wd_b;
    logic [1:0]     op;

    complex_pipe_alu_if #(.W(W), .AW(AW)) bus_s ();
    complex_pipe_alu_if #(.W(W), .AW(AW)) bus_t ();

    assign bus_s.write = write;      assign bus_t.write = write;
    assign bus_s.wr_addr_a = wa_a;   assign bus_t.wr_addr_a = wa_a;
    assign bus_s.wr_addr_b = wa_b;   assign bus_t.wr_addr_b = wa_b;
    assign bus_s.wr_data_a = wd_a;   assign bus_t.wr_data_a = wd_a;
    assign bus_s.wr_data_b = wd_b;   assign bus_t.wr_data_b = wd_b;
    assign bus_s.in_valid = in_valid; assign bus_t.in_valid = in_valid;
    assign bus_s.op = op;            assign bus_t.op = op;
    assign bus_s.rd_addr_a = ra_a;   assign bus_t.rd_addr_a = ra_a;
    assign bus_s.rd_addr_b = ra_b;   assign bus_t.rd_addr_b = ra_b;
    assign bus_s.out_ready = out_ready; assign bus_t.out_ready = out_ready;

    complex_pipe_alu #(.W(W), .DEPTH(DEPTH), .AW(AW), .SATURATE(1)) dut_s (
        .clk(clk), .reset(reset), .alu(bus_s));
    complex_pipe_alu #(.W(W), .DEPTH(DEPTH), .AW(AW), .SATURATE(0)) dut_t (
        .clk(clk), .reset(reset), .alu(bus_t));

    typedef struct packed {
        logic [2*RW-1:0] res;
        logic [2*W-1:0]  sat_s;
        logic [2*W-1:0]  sat_t;
        logic            ovr;
        logic            ovi;
    } exp_t;

    exp_t           sb[$];
    logic [2*W-1:0] mem [DEPTH];
    int             n_chk = 0;
    int             n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic int sx(input logic [W-1:0] v);
        return int'($signed(v));
    endfunction

    function automatic int clampw(input int v);
        if (v > HI) return HI;
        if (v < LO) return LO;
        return v;
    endfunction

    function automatic exp_t model(input logic [1:0] o, input logic [2*W-1:0] av, input logic [2*W-1:0] bv);
        exp_t e;
        int a, b, c, d, re, im;
        a = sx(av[2*W-1:W]); b = sx(av[W-1:0]);
        c = sx(bv[2*W-1:W]); d = sx(bv[W-1:0]);
        case (o)
            2'b00:   begin re = a + c;         im = b + d;         end
            2'b01:   begin re = a - c;         im = b - d;         end
            2'b10:   begin re = a * c - b * d; im = a * d + b * c; end
            default: begin re = a * c + b * d; im = b * c - a * d; end
        endcase
        e.res   = {RW'(re), RW'(im)};
        e.sat_s = {W'(clampw(re)), W'(clampw(im))};
        e.sat_t = {W'(re), W'(im)};
        e.ovr   = (re > HI) || (re < LO);
        e.ovi   = (im > HI) || (im < LO);
        return e;
    endfunction

    // Monitor: inputs settle 1ns after posedge, so negedge values are what the next edge sees.
    logic            was_stall = 1'b0;
    logic [2*RW-1:0] held;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            sb.delete();
            for (int i = 0; i < DEPTH; i++) mem[i] = '0;
            was_stall = 1'b0;
        end else begin
            if (bus_s.out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("spurious_out", 64'(bus_s.result), 64'hdead);
                end else begin
                    e = sb.pop_front();
                    chk("result",   64'(bus_s.result), 64'(e.res));
                    chk("sat",      64'(bus_s.result_sat), 64'(e.sat_s));
                    chk("ovf_re",   64'(bus_s.overflow_real), 64'(e.ovr));
                    chk("ovf_im",   64'(bus_s.overflow_imaginary), 64'(e.ovi));
                    chk("t_valid",  64'(bus_t.out_valid), 64'd1);
                    chk("t_result", 64'(bus_t.result), 64'(e.res));
                    chk("trunc",    64'(bus_t.result_sat), 64'(e.sat_t));
                end
            end
            if (bus_s.out_valid && !out_ready) begin
                if (was_stall) chk("stall_hold", 64'(bus_s.result), 64'(held));
                chk("stall_in_ready", 64'(bus_s.in_ready), 64'd0);
                held      = bus_s.result;
                was_stall = 1'b1;
            end else begin
                was_stall = 1'b0;
            end
            if (write) begin
                mem[wa_a] = wd_a;
                mem[wa_b] = wd_b;
            end
            if (in_valid && bus_s.in_ready) sb.push_back(model(op, mem[ra_a], mem[ra_b]));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [1:0] o, input logic [AW-1:0] a, input logic [AW-1:0] b);
        logic ok;
        ok = 1'b0;
        in_valid = 1'b1; op = o; ra_a = a; ra_b = b;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus_s.in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("req_timeout", 64'd0, 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [2*W-1:0] da,
                      input logic [AW-1:0] b, input logic [2*W-1:0] db);
        write = 1'b1; wa_a = a; wd_a = da; wa_b = b; wd_b = db;
        tick();
        write = 1'b0;
    endtask

    task automatic drain;
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0 && !bus_s.out_valid) break;
            tick();
        end
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [2*RW-1:0] add_exp;
        logic            acc;
        reset = 1'b1; write = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        wa_a = '0; wa_b = '0; wd_a = '0; wd_b = '0; ra_a = '0; ra_b = '0; op = 2'b00;
        tick(); tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(bus_s.out_valid), 64'd0);
        chk("rst_result",    64'(bus_s.result), 64'd0);
        chk("rst_sat",       64'(bus_s.result_sat), 64'd0);
        chk("rst_ovf",       64'({bus_s.overflow_real, bus_s.overflow_imaginary}), 64'd0);
        chk("rst_in_ready",  64'(bus_s.in_ready), 64'd1);
        tick();

        // 9-13i at 2, 4+6i at 3; ADD with latency check
        wr(5'd2, 10'h133, 5'd3, 10'h086);
        req(2'b00, 5'd2, 5'd3);
        @(negedge clk);
        chk("lat_k", 64'(bus_s.out_valid), 64'd0);
        tick();
        @(negedge clk);
        chk("lat_k1", 64'(bus_s.out_valid), 64'd1);
        add_exp = {11'd13, 11'h7F9};
        chk("add_lit", 64'(bus_s.result), 64'(add_exp));
        drain();

        req(2'b01, 5'd2, 5'd3);
        req(2'b10, 5'd2, 5'd3);
        req(2'b11, 5'd2, 5'd3);
        drain();

        // 13-5i at 4, -3-5i at 5
        wr(5'd4, 10'h1BB, 5'd5, 10'h3BB);
        req(2'b10, 5'd4, 5'd5);
        drain();

        fork
            begin
                req(2'b00, 5'd4, 5'd5);
                req(2'b10, 5'd2, 5'd5);
                req(2'b11, 5'd4, 5'd3);
                req(2'b01, 5'd5, 5'd2);
            end
            begin
                tick(); tick();
                out_ready = 1'b0;
                tick(); tick(); tick();
                out_ready = 1'b1;
            end
        join
        drain();

        // Write and read of the same address in one cycle
        write = 1'b1; wa_a = 5'd6; wd_a = 10'h0E3; wa_b = 5'd7; wd_b = 10'h3C1;
        req(2'b10, 5'd6, 5'd7);
        write = 1'b0;
        drain();

        wr(5'd8, 10'h0A5, 5'd8, 10'h25A);
        req(2'b00, 5'd8, 5'd8);
        drain();

        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            acc = in_valid && bus_s.in_ready;
            tick();
            write = 1'($urandom_range(0, 1));
            wa_a = 5'($urandom_range(0, 7)); wa_b = 5'($urandom_range(0, 7));
            wd_a = 10'($urandom); wd_b = 10'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid || acc) begin
                in_valid = 1'($urandom_range(0, 1));
                op = 2'($urandom);
                ra_a = 5'($urandom_range(0, 7)); ra_b = 5'($urandom_range(0, 7));
            end
        end
        @(negedge clk);
        tick();
        write = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        drain();

        // Reset with results in flight and a write pending
        req(2'b10, 5'd2, 5'd3);
        req(2'b00, 5'd4, 5'd5);
        reset = 1'b1;
        write = 1'b1; wa_a = 5'd2; wd_a = 10'h155; wa_b = 5'd3; wd_b = 10'h0AA;
        tick();
        reset = 1'b0; write = 1'b0;
        @(negedge clk);
        chk("rst_mid_out_valid", 64'(bus_s.out_valid), 64'd0);
        req(2'b00, 5'd2, 5'd3);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
